// File: rtl/ddr2_wr_burst_ctrl.sv
// Write-burst controller: drains WRITE_BURST words from the write FIFO, packs
// them pairwise into MIG write-data beats, then posts one write command.
module ddr2_wr_burst_ctrl #(
  parameter int DATA_WIDTH     = 64,
  parameter int APP_DATA_WIDTH = 128,
  parameter int WRITE_BURST    = 8,
  parameter int ADDR_WIDTH     = 31,
  parameter int ADDR_BASE      = 0,
  parameter int ADDR_INC       = 8,
  parameter int ADDR_LIMIT     = 1 << 20
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        enable_i,
  input  logic                        phy_init_done_i,
  input  logic [9:0]                  rd_data_count_i,
  input  logic [DATA_WIDTH-1:0]       data_out_i,
  input  logic                        dout_vd_i,
  output logic                        rd_fifo_o,
  input  logic                        app_af_afull_i,
  input  logic                        app_wdf_afull_i,
  output logic                        app_af_wren_o,
  output logic [ADDR_WIDTH-1:0]       app_af_addr_o,
  output logic [2:0]                  app_af_cmd_o,
  output logic                        app_wdf_wren_o,
  output logic [APP_DATA_WIDTH-1:0]   app_wdf_data_o,
  output logic [APP_DATA_WIDTH/8-1:0] app_wdf_mask_data_o,
  output logic                        busy_o,
  output logic [15:0]                 burst_count_o
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, CMD} state_e;

  localparam int CNT_W = $clog2(WRITE_BURST + 1);
  localparam int AX_W  = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0]      BURST_LEN = CNT_W'(WRITE_BURST);
  localparam logic [9:0]            BURST_LVL = 10'(WRITE_BURST);
  localparam logic [ADDR_WIDTH-1:0] BASE_ADDR = ADDR_WIDTH'(ADDR_BASE);
  localparam logic [AX_W-1:0]       INC_X     = AX_W'(ADDR_INC);
  localparam logic [AX_W-1:0]       LIMIT_X   = AX_W'(ADDR_LIMIT);

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          rdCnt_q, rdCnt_d;
  logic [CNT_W-1:0]          vdCnt_q, vdCnt_d;
  logic                      pairSel_q, pairSel_d;
  logic [DATA_WIDTH-1:0]     lowWord_q, lowWord_d;
  logic                      rdFifo_q, rdFifo_d;
  logic                      wdfWren_q, wdfWren_d;
  logic [APP_DATA_WIDTH-1:0] wdfData_q, wdfData_d;
  logic                      afWren_q, afWren_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [15:0]               burstCnt_q, burstCnt_d;
  logic                      busy_q, busy_d;
  logic [AX_W-1:0]           nextAddr;
  logic                      startOk;

  assign startOk = phy_init_done_i & enable_i & (rd_data_count_i >= BURST_LVL)
                   & ~app_af_afull_i & ~app_wdf_afull_i;

  always_comb begin
    state_d    = state_q;
    rdCnt_d    = rdCnt_q;
    vdCnt_d    = vdCnt_q;
    pairSel_d  = pairSel_q;
    lowWord_d  = lowWord_q;
    wdfData_d  = wdfData_q;
    addr_d     = addr_q;
    burstCnt_d = burstCnt_q;
    rdFifo_d   = 1'b0;
    wdfWren_d  = 1'b0;
    afWren_d   = 1'b0;
    nextAddr   = {1'b0, addr_q} + INC_X;

    // Pair assembly only while a burst is in flight; stray valids elsewhere are dropped.
    if ((state_q == READ || state_q == DRAIN) && dout_vd_i && vdCnt_q != BURST_LEN) begin
      vdCnt_d = vdCnt_q + 1'b1;
      if (!pairSel_q) begin
        lowWord_d = data_out_i;
        pairSel_d = 1'b1;
      end else begin
        wdfData_d = {data_out_i, lowWord_q};
        wdfWren_d = 1'b1;
        pairSel_d = 1'b0;
      end
    end

    case (state_q)
      IDLE: begin
        if (startOk) begin
          state_d   = READ;
          rdFifo_d  = 1'b1;
          rdCnt_d   = CNT_W'(1);
          vdCnt_d   = '0;
          pairSel_d = 1'b0;
        end
      end
      READ: begin
        if (rdCnt_q == BURST_LEN) begin
          state_d = DRAIN;
        end else if (!app_wdf_afull_i) begin
          rdFifo_d = 1'b1;
          rdCnt_d  = rdCnt_q + 1'b1;
        end
      end
      DRAIN: begin
        // The last beat is on the bus this cycle, so the command trails it by one.
        if (vdCnt_q == BURST_LEN) begin
          state_d  = CMD;
          afWren_d = 1'b1;
        end
      end
      CMD: begin
        state_d    = IDLE;
        burstCnt_d = burstCnt_q + 16'd1;
        addr_d     = (nextAddr >= LIMIT_X) ? BASE_ADDR : nextAddr[ADDR_WIDTH-1:0];
        rdCnt_d    = '0;
        vdCnt_d    = '0;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      rdCnt_q    <= '0;
      vdCnt_q    <= '0;
      pairSel_q  <= 1'b0;
      lowWord_q  <= '0;
      rdFifo_q   <= 1'b0;
      wdfWren_q  <= 1'b0;
      wdfData_q  <= '0;
      afWren_q   <= 1'b0;
      addr_q     <= BASE_ADDR;
      burstCnt_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rdCnt_q    <= rdCnt_d;
      vdCnt_q    <= vdCnt_d;
      pairSel_q  <= pairSel_d;
      lowWord_q  <= lowWord_d;
      rdFifo_q   <= rdFifo_d;
      wdfWren_q  <= wdfWren_d;
      wdfData_q  <= wdfData_d;
      afWren_q   <= afWren_d;
      addr_q     <= addr_d;
      burstCnt_q <= burstCnt_d;
      busy_q     <= busy_d;
    end
  end

  assign rd_fifo_o           = rdFifo_q;
  assign app_af_wren_o       = afWren_q;
  assign app_af_addr_o       = addr_q;
  assign app_af_cmd_o        = 3'b000;
  assign app_wdf_wren_o      = wdfWren_q;
  assign app_wdf_data_o      = wdfData_q;
  assign app_wdf_mask_data_o = '0;
  assign busy_o              = busy_q;
  assign burst_count_o       = burstCnt_q;

endmodule

// File: tb/tb_ddr2_wr_burst_ctrl.sv
// Self-checking bench for ddr2_wr_burst_ctrl: a write-FIFO model feeds the DUT
// while a scoreboard checks packed beats, command addresses and cycle timing.
module tb_ddr2_wr_burst_ctrl;

  localparam int WB    = 8;
  localparam int LIMIT = 32;
  localparam int INC   = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable, phy_init_done;
  logic [9:0]   rd_data_count;
  logic [63:0]  data_out;
  logic         dout_vd;
  logic         rd_fifo;
  logic         app_af_afull, app_wdf_afull;
  logic         app_af_wren;
  logic [30:0]  app_af_addr;
  logic [2:0]   app_af_cmd;
  logic         app_wdf_wren;
  logic [127:0] app_wdf_data;
  logic [15:0]  app_wdf_mask_data;
  logic         busy;
  logic [15:0]  burst_count;

  always #5 clk = ~clk;

  ddr2_wr_burst_ctrl #(.ADDR_LIMIT(LIMIT)) dut (
    .clk_i(clk), .reset_i(reset), .enable_i(enable), .phy_init_done_i(phy_init_done),
    .rd_data_count_i(rd_data_count), .data_out_i(data_out), .dout_vd_i(dout_vd),
    .rd_fifo_o(rd_fifo), .app_af_afull_i(app_af_afull), .app_wdf_afull_i(app_wdf_afull),
    .app_af_wren_o(app_af_wren), .app_af_addr_o(app_af_addr), .app_af_cmd_o(app_af_cmd),
    .app_wdf_wren_o(app_wdf_wren), .app_wdf_data_o(app_wdf_data),
    .app_wdf_mask_data_o(app_wdf_mask_data), .busy_o(busy), .burst_count_o(burst_count)
  );

  // Upstream FIFO model: one-cycle read latency, flushed by the shared reset.
  logic [63:0] fifoMem [0:1023];
  int wrPtr = 0;
  int rdPtr = 0;
  assign rd_data_count = 10'(wrPtr - rdPtr);

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      rdPtr    <= wrPtr;
      dout_vd  <= 1'b0;
      data_out <= '0;
    end else if (rd_fifo) begin
      data_out <= fifoMem[rdPtr % 1024];
      rdPtr    <= rdPtr + 1;
      dout_vd  <= 1'b1;
    end else begin
      dout_vd  <= 1'b0;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int passCnt = 0;
  int totalCnt = 0;

  logic [127:0] expBeatQ[$];
  logic [30:0]  expAddrQ[$];
  logic [63:0]  halfWord;
  bit           halfPending = 0;
  int           groupWords = 0;
  logic [30:0]  addrModel = '0;
  int           beatsSinceCmd = 0;
  bit           prevBusy = 0;

  int          rdLog[$];
  int          beatLog[$];
  int          cmdLog[$];
  int          busyFallLog[$];
  logic [30:0] cmdAddrLog[$];

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Drives one word into the FIFO and records the beats/command it implies.
  task automatic applyStimulus(input logic [63:0] v);
    @(negedge clk);
    fifoMem[wrPtr % 1024] = v;
    wrPtr++;
    if (halfPending) begin
      expBeatQ.push_back({v, halfWord});
      halfPending = 0;
    end else begin
      halfWord    = v;
      halfPending = 1;
    end
    groupWords++;
    if (groupWords == WB) begin
      groupWords = 0;
      expAddrQ.push_back(addrModel);
      addrModel = (32'(addrModel) + INC >= LIMIT) ? 31'd0 : addrModel + 31'(INC);
    end
  endtask

  task automatic clearLogs();
    rdLog.delete(); beatLog.delete(); cmdLog.delete();
    busyFallLog.delete(); cmdAddrLog.delete();
  endtask

  task automatic checkResetVals(input string tag);
    checkOutput({tag, "_rd_fifo"}, 128'(rd_fifo), 128'(0));
    checkOutput({tag, "_busy"}, 128'(busy), 128'(0));
    checkOutput({tag, "_wdf_wren"}, 128'(app_wdf_wren), 128'(0));
    checkOutput({tag, "_af_wren"}, 128'(app_af_wren), 128'(0));
    checkOutput({tag, "_af_addr"}, 128'(app_af_addr), 128'(0));
    checkOutput({tag, "_af_cmd"}, 128'(app_af_cmd), 128'(0));
    checkOutput({tag, "_wdf_data"}, app_wdf_data, 128'(0));
    checkOutput({tag, "_mask"}, 128'(app_wdf_mask_data), 128'(0));
    checkOutput({tag, "_burst_count"}, 128'(burst_count), 128'(0));
  endtask

  task automatic resetDut(input bit doCheck);
    reset = 1'b1;
    #1;
    if (doCheck) checkResetVals("rst_mid");
    repeat (2) @(negedge clk);
    expBeatQ.delete();
    expAddrQ.delete();
    halfPending   = 0;
    groupWords    = 0;
    addrModel     = '0;
    beatsSinceCmd = 0;
    clearLogs();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic waitRd(input int n, input int bound);
    for (int k = 0; k < bound; k++) begin
      @(negedge clk); #1;
      if (rdLog.size() >= n) break;
    end
    checkOutput("rd_reached", 128'(rdLog.size() >= n), 128'(1));
  endtask

  task automatic waitCmds(input int n, input int bound);
    for (int k = 0; k < bound; k++) begin
      @(negedge clk); #1;
      if (cmdLog.size() >= n && !busy) break;
    end
    checkOutput("cmds_seen", 128'(cmdLog.size()), 128'(n));
  endtask

  // Output monitor: pops the scoreboard on every beat and command.
  always @(negedge clk) begin
    if (!reset) begin
      if (rd_fifo) rdLog.push_back(cyc);
      if (app_wdf_wren) begin
        beatLog.push_back(cyc);
        beatsSinceCmd++;
        checkOutput("beat_expected", 128'(expBeatQ.size() != 0), 128'(1));
        if (expBeatQ.size() != 0) checkOutput("beat_data", app_wdf_data, expBeatQ.pop_front());
      end
      if (app_af_wren) begin
        cmdLog.push_back(cyc);
        cmdAddrLog.push_back(app_af_addr);
        checkOutput("cmd_code", 128'(app_af_cmd), 128'(0));
        checkOutput("cmd_after_beats", 128'(beatsSinceCmd), 128'(WB / 2));
        beatsSinceCmd = 0;
        checkOutput("cmd_expected", 128'(expAddrQ.size() != 0), 128'(1));
        if (expAddrQ.size() != 0) checkOutput("cmd_addr", 128'(app_af_addr), 128'(expAddrQ.pop_front()));
      end
      if (prevBusy && !busy) busyFallLog.push_back(cyc);
    end
    prevBusy = busy;
  end

  typedef struct {
    bit phy;
    bit en;
    bit aaf;
    bit waf;
    int level;
    bit start;
  } vec_t;

  initial begin
    vec_t        vecs[9];
    logic [30:0] expWrap[5];
    int          markCyc;
    logic [15:0] bcBefore;
    logic [63:0] wordVal;

    vecs[0] = '{0, 1, 0, 0, 8, 0};
    vecs[1] = '{1, 0, 0, 0, 8, 0};
    vecs[2] = '{1, 1, 1, 0, 8, 0};
    vecs[3] = '{1, 1, 0, 1, 8, 0};
    vecs[4] = '{1, 1, 0, 0, 8, 1};
    vecs[5] = '{1, 1, 0, 0, 7, 0};
    vecs[6] = '{1, 1, 0, 0, 8, 1};
    vecs[7] = '{0, 0, 0, 0, 8, 0};
    vecs[8] = '{1, 1, 0, 0, 8, 1};
    expWrap = '{31'd0, 31'd8, 31'd16, 31'd24, 31'd0};

    reset = 1'b1; enable = 1'b0; phy_init_done = 1'b0;
    app_af_afull = 1'b0; app_wdf_afull = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkResetVals("rst_init");

    // First burst: exact latency of reads, beats, command and busy release.
    phy_init_done = 1'b1; enable = 1'b1;
    clearLogs();
    for (int i = 1; i <= 8; i++) applyStimulus(64'(i));
    markCyc = cyc;
    waitCmds(1, 40);
    checkOutput("b1_rd_count", 128'(rdLog.size()), 128'(8));
    if (rdLog.size() >= 8) begin
      checkOutput("b1_start_lat", 128'(rdLog[0] - markCyc), 128'(1));
      checkOutput("b1_rd_contig", 128'(rdLog[7] - rdLog[0]), 128'(7));
      checkOutput("b1_beat_count", 128'(beatLog.size()), 128'(4));
      for (int i = 0; i < beatLog.size() && i < 4; i++)
        checkOutput($sformatf("b1_beat%0d_lat", i), 128'(beatLog[i] - rdLog[0]), 128'(3 + 2 * i));
      if (cmdLog.size() >= 1) checkOutput("b1_cmd_lat", 128'(cmdLog[0] - rdLog[0]), 128'(10));
      if (busyFallLog.size() >= 1) checkOutput("b1_busy_fall", 128'(busyFallLog[0] - rdLog[0]), 128'(11));
    end
    checkOutput("b1_burst_count", 128'(burst_count), 128'(1));

    // Start-condition table.
    wordVal = 64'd9;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      phy_init_done = vecs[i].phy; enable = vecs[i].en;
      app_af_afull = vecs[i].aaf; app_wdf_afull = vecs[i].waf;
      clearLogs();
      while ((wrPtr - rdPtr) < vecs[i].level) begin
        applyStimulus(wordVal);
        wordVal++;
      end
      markCyc  = cyc;
      bcBefore = burst_count;
      repeat (4) @(negedge clk);
      #1;
      checkOutput($sformatf("vec%0d_start", i), 128'(rdLog.size() != 0), 128'(vecs[i].start));
      if (vecs[i].start) begin
        if (rdLog.size() != 0) checkOutput($sformatf("vec%0d_lat", i), 128'(rdLog[0] - markCyc), 128'(1));
        waitCmds(1, 40);
        checkOutput($sformatf("vec%0d_count", i), 128'(burst_count), 128'(bcBefore + 16'd1));
      end else begin
        checkOutput($sformatf("vec%0d_busy", i), 128'(busy), 128'(0));
      end
    end

    // Write-data FIFO backpressure splitting a pair.
    @(negedge clk);
    phy_init_done = 1'b1; enable = 1'b1; app_af_afull = 1'b0; app_wdf_afull = 1'b0;
    clearLogs();
    for (int i = 0; i < 8; i++) applyStimulus(64'h100 + 64'(i));
    waitRd(3, 20);
    app_wdf_afull = 1'b1;
    repeat (3) @(negedge clk);
    app_wdf_afull = 1'b0;
    waitCmds(1, 40);
    checkOutput("stall_rd_count", 128'(rdLog.size()), 128'(8));
    if (rdLog.size() >= 4) checkOutput("stall_gap", 128'(rdLog[3] - rdLog[2]), 128'(4));
    checkOutput("stall_beats", 128'(beatLog.size()), 128'(4));

    // Reset after three reads: no command, no stale half-word afterwards.
    clearLogs();
    for (int i = 0; i < 8; i++) applyStimulus(64'h200 + 64'(i));
    waitRd(3, 20);
    resetDut(1);
    for (int i = 0; i < 8; i++) applyStimulus(64'h301 + 64'(i));
    waitCmds(1, 40);
    checkOutput("post_rst_beats", 128'(beatLog.size()), 128'(4));
    checkOutput("post_rst_count", 128'(burst_count), 128'(1));

    // Five bursts wrap the address at the limit.
    @(negedge clk);
    resetDut(0);
    for (int i = 0; i < 40; i++) applyStimulus(64'h400 + 64'(i));
    waitCmds(5, 150);
    checkOutput("wrap_count", 128'(burst_count), 128'(5));
    for (int i = 0; i < cmdAddrLog.size() && i < 5; i++)
      checkOutput($sformatf("wrap_addr%0d", i), 128'(cmdAddrLog[i]), 128'(expWrap[i]));

    // Address FIFO full blocks start; on release two back-to-back bursts.
    @(negedge clk);
    resetDut(0);
    app_af_afull = 1'b1;
    for (int i = 0; i < 16; i++) applyStimulus(64'h500 + 64'(i));
    repeat (5) @(negedge clk);
    #1;
    checkOutput("aaf_no_start", 128'(rdLog.size()), 128'(0));
    checkOutput("aaf_idle", 128'(busy), 128'(0));
    @(negedge clk);
    app_af_afull = 1'b0;
    waitCmds(2, 80);
    checkOutput("b2b_rd_count", 128'(rdLog.size()), 128'(16));
    if (rdLog.size() >= 9) checkOutput("b2b_spacing", 128'(rdLog[8] - rdLog[0]), 128'(12));
    if (cmdAddrLog.size() >= 2) begin
      checkOutput("b2b_addr0", 128'(cmdAddrLog[0]), 128'(0));
      checkOutput("b2b_addr1", 128'(cmdAddrLog[1]), 128'(8));
    end

    enable = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("beats_drained", 128'(expBeatQ.size()), 128'(0));
    checkOutput("cmds_drained", 128'(expAddrQ.size()), 128'(0));

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "[TB] timeout");
  end

endmodule
